// File: rtl/atm_controller_if.sv
// Keypad, admin and display bundle between the front panel and atm_controller.
// The master side drives strobes and data; the slave (the controller) returns status.
interface atm_controller_if #(
  parameter int ACC_W = 4,
  parameter int PIN_W = 14,
  parameter int BAL_W = 14
);
  logic             card_valid;
  logic [ACC_W-1:0] acc_num;
  logic             pin_valid;
  logic [PIN_W-1:0] pin;
  logic             op_valid;
  logic [2:0]       operation;
  logic [BAL_W-1:0] amount;
  logic [PIN_W-1:0] new_pin;
  logic             cfg_we;
  logic [ACC_W-1:0] cfg_acc;
  logic [PIN_W-1:0] cfg_pin;
  logic [BAL_W-1:0] cfg_bal;
  logic [BAL_W-1:0] balance;
  logic             success;
  logic             done;
  logic [2:0]       err_code;
  logic             locked;
  logic [2:0]       state;

  modport master (
    output card_valid, acc_num, pin_valid, pin, op_valid, operation, amount, new_pin,
           cfg_we, cfg_acc, cfg_pin, cfg_bal,
    input  balance, success, done, err_code, locked, state
  );

  modport slave (
    input  card_valid, acc_num, pin_valid, pin, op_valid, operation, amount, new_pin,
           cfg_we, cfg_acc, cfg_pin, cfg_bal,
    output balance, success, done, err_code, locked, state
  );
endinterface

// File: rtl/atm_controller.sv
// Session-based multi-account ATM controller: card check, PIN retries with lockout,
// then repeated balance/withdraw/deposit/PIN-change transactions until exit or idle timeout.
module atm_controller #(
  parameter int NUM_ACCTS = 10,
  parameter int ACC_W     = 4,
  parameter int PIN_W     = 14,
  parameter int BAL_W     = 14,
  parameter int MAX_TRIES = 3,
  parameter int TIMEOUT   = 16
) (
  input logic            clk,
  input logic            rst,
  atm_controller_if.slave bus
);
  localparam int TRY_W  = $clog2(MAX_TRIES + 1);
  localparam int TO_W   = $clog2(TIMEOUT + 1);
  localparam int ACC_W1 = ACC_W + 1;
  localparam logic [ACC_W:0]     ACC_LIM  = ACC_W1'(NUM_ACCTS);
  localparam logic [TRY_W-1:0]   TRY_LAST = TRY_W'(MAX_TRIES - 1);
  localparam logic [TO_W-1:0]    TO_LAST  = TO_W'(TIMEOUT - 1);

  localparam logic [2:0] ERR_NONE = 3'd0, ERR_BAD_ACC = 3'd1, ERR_BAD_PIN = 3'd2,
                         ERR_LOCKED = 3'd3, ERR_NSF = 3'd4, ERR_OVF = 3'd5,
                         ERR_BAD_OP = 3'd6, ERR_TIMEOUT = 3'd7;
  localparam logic [2:0] OP_BAL = 3'd1, OP_WD = 3'd2, OP_DEP = 3'd3, OP_CHG = 3'd4, OP_EXIT = 3'd5;

  typedef enum logic [2:0] {IDLE = 3'd0, AUTH = 3'd1, MENU = 3'd2, EXEC = 3'd3} state_t;

  state_t             state_q, state_n;
  logic [ACC_W-1:0]   acc_q, acc_n;
  logic [2:0]         op_q, op_n;
  logic [BAL_W-1:0]   amt_q, amt_n;
  logic [PIN_W-1:0]   npin_q, npin_n;
  logic [TO_W-1:0]    to_q, to_n;
  logic [BAL_W-1:0]   balance_q, balance_n;
  logic               success_q, success_n;
  logic               done_q, done_n;
  logic [2:0]         err_q, err_n;
  logic               locked_q, locked_n;

  logic [PIN_W-1:0]   pin_mem [NUM_ACCTS];
  logic [BAL_W-1:0]   bal_mem [NUM_ACCTS];
  logic [TRY_W-1:0]   tries_q [NUM_ACCTS];
  logic [NUM_ACCTS-1:0] lock_q;

  logic               pin_we, bal_we, cfg_clr, tries_inc, tries_clr, lock_set;
  logic [ACC_W-1:0]   wr_idx;
  logic [PIN_W-1:0]   wr_pin;
  logic [BAL_W-1:0]   wr_bal;
  logic [BAL_W-1:0]   cur_bal;
  logic [BAL_W:0]     dep_sum;

  // Next-state, output and storage-update decode
  always_comb begin
    state_n   = state_q;
    acc_n     = acc_q;
    op_n      = op_q;
    amt_n     = amt_q;
    npin_n    = npin_q;
    to_n      = to_q;
    balance_n = balance_q;
    success_n = success_q;
    err_n     = err_q;
    locked_n  = locked_q;
    done_n    = 1'b0;
    pin_we    = 1'b0;
    bal_we    = 1'b0;
    cfg_clr   = 1'b0;
    tries_inc = 1'b0;
    tries_clr = 1'b0;
    lock_set  = 1'b0;
    wr_idx    = acc_q;
    wr_pin    = npin_q;
    cur_bal   = bal_mem[acc_q];
    wr_bal    = cur_bal;
    dep_sum   = {1'b0, cur_bal} + {1'b0, amt_q};

    case (state_q)
      IDLE: begin
        to_n = '0;
        if (bus.cfg_we) begin
          if ({1'b0, bus.cfg_acc} < ACC_LIM) begin
            pin_we  = 1'b1;
            bal_we  = 1'b1;
            cfg_clr = 1'b1;
            wr_idx  = bus.cfg_acc;
            wr_pin  = bus.cfg_pin;
            wr_bal  = bus.cfg_bal;
          end
        end else if (bus.card_valid) begin
          if ({1'b0, bus.acc_num} >= ACC_LIM) begin
            done_n = 1'b1; success_n = 1'b0; err_n = ERR_BAD_ACC; locked_n = 1'b0;
          end else if (lock_q[bus.acc_num]) begin
            done_n = 1'b1; success_n = 1'b0; err_n = ERR_LOCKED; locked_n = 1'b1;
          end else begin
            acc_n   = bus.acc_num;
            state_n = AUTH;
          end
        end
      end

      AUTH: begin
        if (bus.pin_valid) begin
          to_n = '0;
          if (bus.pin == pin_mem[acc_q]) begin
            tries_clr = 1'b1;
            balance_n = cur_bal;
            state_n   = MENU;
          end else begin
            tries_inc = 1'b1;
            done_n    = 1'b1;
            success_n = 1'b0;
            if (tries_q[acc_q] >= TRY_LAST) begin
              lock_set = 1'b1; err_n = ERR_LOCKED; locked_n = 1'b1; state_n = IDLE;
            end else begin
              err_n = ERR_BAD_PIN; locked_n = 1'b0;
            end
          end
        end else if (to_q == TO_LAST) begin
          done_n = 1'b1; success_n = 1'b0; err_n = ERR_TIMEOUT; locked_n = 1'b0;
          to_n = '0; state_n = IDLE;
        end else begin
          to_n = to_q + 1'b1;
        end
      end

      MENU: begin
        if (bus.op_valid) begin
          to_n = '0;
          case (bus.operation)
            OP_BAL, OP_WD, OP_DEP, OP_CHG: begin
              op_n    = bus.operation;
              amt_n   = bus.amount;
              npin_n  = bus.new_pin;
              state_n = EXEC;
            end
            OP_EXIT: begin
              done_n = 1'b1; success_n = 1'b1; err_n = ERR_NONE; locked_n = 1'b0;
              state_n = IDLE;
            end
            default: begin
              done_n = 1'b1; success_n = 1'b0; err_n = ERR_BAD_OP; locked_n = 1'b0;
            end
          endcase
        end else if (to_q == TO_LAST) begin
          done_n = 1'b1; success_n = 1'b0; err_n = ERR_TIMEOUT; locked_n = 1'b0;
          to_n = '0; state_n = IDLE;
        end else begin
          to_n = to_q + 1'b1;
        end
      end

      EXEC: begin
        state_n   = MENU;
        to_n      = '0;
        done_n    = 1'b1;
        success_n = 1'b1;
        err_n     = ERR_NONE;
        locked_n  = 1'b0;
        balance_n = cur_bal;
        case (op_q)
          OP_WD: begin
            if (amt_q > cur_bal) begin
              success_n = 1'b0; err_n = ERR_NSF;
            end else begin
              bal_we = 1'b1; wr_bal = cur_bal - amt_q; balance_n = cur_bal - amt_q;
            end
          end
          OP_DEP: begin
            // The carry out of the widened sum flags an unrepresentable balance
            if (dep_sum[BAL_W]) begin
              success_n = 1'b0; err_n = ERR_OVF;
            end else begin
              bal_we = 1'b1; wr_bal = dep_sum[BAL_W-1:0]; balance_n = dep_sum[BAL_W-1:0];
            end
          end
          OP_CHG: begin
            pin_we = 1'b1;
            wr_pin = npin_q;
          end
          default: ;
        endcase
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      op_q      <= '0;
      amt_q     <= '0;
      npin_q    <= '0;
      to_q      <= '0;
      balance_q <= '0;
      success_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= ERR_NONE;
      locked_q  <= 1'b0;
      lock_q    <= '0;
      for (int i = 0; i < NUM_ACCTS; i++) tries_q[i] <= '0;
    end else begin
      state_q   <= state_n;
      acc_q     <= acc_n;
      op_q      <= op_n;
      amt_q     <= amt_n;
      npin_q    <= npin_n;
      to_q      <= to_n;
      balance_q <= balance_n;
      success_q <= success_n;
      done_q    <= done_n;
      err_q     <= err_n;
      locked_q  <= locked_n;
      if (cfg_clr) begin
        tries_q[wr_idx] <= '0;
        lock_q[wr_idx]  <= 1'b0;
      end
      if (tries_clr) tries_q[acc_q] <= '0;
      if (tries_inc) tries_q[acc_q] <= tries_q[acc_q] + 1'b1;
      if (lock_set)  lock_q[acc_q]  <= 1'b1;
    end
  end

  // Account contents survive reset; a reset edge aborts any pending commit
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (pin_we) pin_mem[wr_idx] <= wr_pin;
      if (bal_we) bal_mem[wr_idx] <= wr_bal;
    end
  end

  assign bus.balance  = balance_q;
  assign bus.success  = success_q;
  assign bus.done     = done_q;
  assign bus.err_code = err_q;
  assign bus.locked   = locked_q;
  assign bus.state    = state_q;
endmodule

// File: tb/tb_atm_controller.sv
// Directed, table-driven bench for atm_controller with hand-written timeout and
// reset-during-EXEC sequences.
module tb_atm_controller;
  localparam int ACC_W = 4;
  localparam int PIN_W = 14;
  localparam int BAL_W = 14;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  atm_controller_if #(.ACC_W(ACC_W), .PIN_W(PIN_W), .BAL_W(BAL_W)) bus ();

  atm_controller #(
    .NUM_ACCTS(10), .ACC_W(ACC_W), .PIN_W(PIN_W), .BAL_W(BAL_W),
    .MAX_TRIES(3), .TIMEOUT(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  typedef enum int {K_CFG, K_CARD, K_PIN, K_OP, K_CFGCARD} kind_t;

  // Expected fields of -1 are not compared for that vector
  typedef struct {
    kind_t kind;
    int a, b, c, d;
    int extra;
    int e_done, e_succ, e_err, e_state, e_bal, e_lock;
  } vec_t;

  int   checks = 0;
  int   failures = 0;
  vec_t vecs[$];

  function automatic vec_t mk(kind_t k, int a, int b, int c, int d, int extra,
                              int e_done, int e_succ, int e_err, int e_state,
                              int e_bal, int e_lock);
    vec_t v;
    v.kind = k; v.a = a; v.b = b; v.c = c; v.d = d; v.extra = extra;
    v.e_done = e_done; v.e_succ = e_succ; v.e_err = e_err;
    v.e_state = e_state; v.e_bal = e_bal; v.e_lock = e_lock;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic clearStrobes();
    bus.card_valid = 1'b0;
    bus.pin_valid  = 1'b0;
    bus.op_valid   = 1'b0;
    bus.cfg_we     = 1'b0;
  endtask

  // Called at a falling edge; returns at the falling edge after the sampling edge (+extra)
  task automatic applyStimulus(input vec_t v);
    case (v.kind)
      K_CFG: begin
        bus.cfg_we = 1'b1; bus.cfg_acc = ACC_W'(v.a);
        bus.cfg_pin = PIN_W'(v.b); bus.cfg_bal = BAL_W'(v.c);
      end
      K_CARD: begin
        bus.card_valid = 1'b1; bus.acc_num = ACC_W'(v.a);
      end
      K_PIN: begin
        bus.pin_valid = 1'b1; bus.pin = PIN_W'(v.a);
      end
      K_OP: begin
        bus.op_valid = 1'b1; bus.operation = 3'(v.a);
        bus.amount = BAL_W'(v.b); bus.new_pin = PIN_W'(v.c);
      end
      K_CFGCARD: begin
        bus.cfg_we = 1'b1; bus.cfg_acc = ACC_W'(v.a);
        bus.cfg_pin = PIN_W'(v.b); bus.cfg_bal = BAL_W'(v.c);
        bus.card_valid = 1'b1; bus.acc_num = ACC_W'(v.d);
      end
      default: ;
    endcase
    @(negedge clk);
    clearStrobes();
    repeat (v.extra) @(negedge clk);
  endtask

  task automatic checkVector(input int idx, input vec_t v);
    if (v.e_done  >= 0) checkOutput($sformatf("v%0d_done", idx), bus.done, v.e_done);
    if (v.e_succ  >= 0) checkOutput($sformatf("v%0d_success", idx), bus.success, v.e_succ);
    if (v.e_err   >= 0) checkOutput($sformatf("v%0d_err", idx), bus.err_code, v.e_err);
    if (v.e_state >= 0) checkOutput($sformatf("v%0d_state", idx), bus.state, v.e_state);
    if (v.e_bal   >= 0) checkOutput($sformatf("v%0d_balance", idx), bus.balance, v.e_bal);
    if (v.e_lock  >= 0) checkOutput($sformatf("v%0d_locked", idx), bus.locked, v.e_lock);
  endtask

  initial begin
    //                kind       a     b      c    d  ex  done succ err st bal  lock
    vecs.push_back(mk(K_CFG,     2,    1234,  500, 0, 0,  0,   -1,  -1, 0, -1,  -1));
    vecs.push_back(mk(K_CARD,    2,    0,     0,   0, 0,  0,   -1,  -1, 1, -1,  -1));
    vecs.push_back(mk(K_PIN,     1234, 0,     0,   0, 0,  0,   -1,  -1, 2, 500, -1));
    vecs.push_back(mk(K_OP,      2,    200,   0,   0, 1,  1,   1,   0,  2, 300, -1));
    vecs.push_back(mk(K_OP,      1,    0,     0,   0, 1,  1,   1,   0,  2, 300, -1));
    vecs.push_back(mk(K_OP,      5,    0,     0,   0, 0,  1,   1,   0,  0, 300, -1));
    vecs.push_back(mk(K_CARD,    2,    0,     0,   0, 0,  0,   -1,  -1, 1, -1,  -1));
    vecs.push_back(mk(K_PIN,     1234, 0,     0,   0, 0,  0,   -1,  -1, 2, 300, -1));
    vecs.push_back(mk(K_OP,      2,    301,   0,   0, 1,  1,   0,   4,  2, 300, -1));
    vecs.push_back(mk(K_OP,      3,    16084, 0,   0, 1,  1,   0,   5,  2, 300, -1));
    vecs.push_back(mk(K_OP,      3,    100,   0,   0, 1,  1,   1,   0,  2, 400, -1));
    vecs.push_back(mk(K_OP,      6,    0,     0,   0, 0,  1,   0,   6,  2, 400, -1));
    vecs.push_back(mk(K_OP,      0,    0,     0,   0, 0,  1,   0,   6,  2, 400, -1));
    vecs.push_back(mk(K_OP,      5,    0,     0,   0, 0,  1,   1,   0,  0, 400, 0));
    vecs.push_back(mk(K_CARD,    2,    0,     0,   0, 0,  0,   -1,  -1, 1, -1,  -1));
    vecs.push_back(mk(K_PIN,     1111, 0,     0,   0, 0,  1,   0,   2,  1, -1,  0));
    vecs.push_back(mk(K_PIN,     2222, 0,     0,   0, 0,  1,   0,   2,  1, -1,  0));
    vecs.push_back(mk(K_PIN,     3333, 0,     0,   0, 0,  1,   0,   3,  0, -1,  1));
    vecs.push_back(mk(K_CARD,    2,    0,     0,   0, 0,  1,   0,   3,  0, -1,  1));
    vecs.push_back(mk(K_CARD,    12,   0,     0,   0, 0,  1,   0,   1,  0, -1,  -1));
    vecs.push_back(mk(K_CFG,     2,    1234,  700, 0, 0,  0,   -1,  -1, 0, -1,  -1));
    vecs.push_back(mk(K_CFGCARD, 3,    55,    9,   2, 0,  0,   -1,  -1, 0, -1,  -1));
    vecs.push_back(mk(K_CARD,    3,    0,     0,   0, 0,  0,   -1,  -1, 1, -1,  -1));
    vecs.push_back(mk(K_PIN,     55,   0,     0,   0, 0,  0,   -1,  -1, 2, 9,   -1));
    vecs.push_back(mk(K_OP,      5,    0,     0,   0, 0,  1,   1,   0,  0, 9,   -1));
    vecs.push_back(mk(K_CARD,    2,    0,     0,   0, 0,  0,   -1,  -1, 1, -1,  -1));
    vecs.push_back(mk(K_PIN,     1234, 0,     0,   0, 0,  0,   -1,  -1, 2, 700, -1));
    vecs.push_back(mk(K_CFG,     2,    1,     9999, 0, 0, 0,   -1,  -1, 2, 700, -1));
    vecs.push_back(mk(K_OP,      1,    0,     0,   0, 1,  1,   1,   0,  2, 700, -1));
    vecs.push_back(mk(K_OP,      4,    0,     4321, 0, 1, 1,   1,   0,  2, 700, -1));
    vecs.push_back(mk(K_OP,      5,    0,     0,   0, 0,  1,   1,   0,  0, 700, -1));
    vecs.push_back(mk(K_CARD,    2,    0,     0,   0, 0,  0,   -1,  -1, 1, -1,  -1));
    vecs.push_back(mk(K_PIN,     1234, 0,     0,   0, 0,  1,   0,   2,  1, -1,  -1));
    vecs.push_back(mk(K_PIN,     4321, 0,     0,   0, 0,  0,   -1,  -1, 2, 700, -1));

    bus.acc_num = '0; bus.pin = '0; bus.operation = '0; bus.amount = '0;
    bus.new_pin = '0; bus.cfg_acc = '0; bus.cfg_pin = '0; bus.cfg_bal = '0;
    clearStrobes();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset_state", bus.state, 0);
    checkOutput("reset_done", bus.done, 0);
    checkOutput("reset_success", bus.success, 0);
    checkOutput("reset_err", bus.err_code, 0);
    checkOutput("reset_balance", bus.balance, 0);
    checkOutput("reset_locked", bus.locked, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkVector(i, vecs[i]);
    end

    // Idle in MENU: the 16th quiet edge after entry fires the timeout
    repeat (15) @(negedge clk);
    checkOutput("timeout_early_done", bus.done, 0);
    checkOutput("timeout_early_state", bus.state, 2);
    @(negedge clk);
    checkOutput("timeout_done", bus.done, 1);
    checkOutput("timeout_success", bus.success, 0);
    checkOutput("timeout_err", bus.err_code, 7);
    checkOutput("timeout_state", bus.state, 0);

    // Reset while a DEPOSIT 50 sits in EXEC must abort the balance update
    applyStimulus(mk(K_CARD, 2, 0, 0, 0, 0, 0, -1, -1, 1, -1, -1));
    applyStimulus(mk(K_PIN, 4321, 0, 0, 0, 0, 0, -1, -1, 2, 700, -1));
    checkOutput("rstx_pre_balance", bus.balance, 700);
    bus.op_valid = 1'b1; bus.operation = 3'd3; bus.amount = BAL_W'(50);
    @(negedge clk);
    clearStrobes();
    checkOutput("rstx_in_exec", bus.state, 3);
    rst = 1'b1;
    #1;
    checkOutput("rstx_state", bus.state, 0);
    checkOutput("rstx_balance", bus.balance, 0);
    checkOutput("rstx_done", bus.done, 0);
    checkOutput("rstx_success", bus.success, 0);
    checkOutput("rstx_err", bus.err_code, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rstx_after_state", bus.state, 0);
    applyStimulus(mk(K_CARD, 2, 0, 0, 0, 0, 0, -1, -1, 1, -1, -1));
    checkOutput("rstx_card_state", bus.state, 1);
    applyStimulus(mk(K_PIN, 4321, 0, 0, 0, 0, 0, -1, -1, 2, 700, -1));
    checkOutput("rstx_menu_state", bus.state, 2);
    checkOutput("rstx_bal_kept", bus.balance, 700);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
